q_tune_seq: RTL and testbench

Q_TUNE_SEQ -- requirements
Module: q_tune_seq

---
 rtl/q_tune_seq.sv | 179 +++++++++++++++++
 tb/tb_q_tune_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_tune_seq.sv
// q_tune_seq: binary-search tuner for a current reference that drives an analog
// Q-factor loop. Each step applies the midpoint of [a, b], waits for the analog
// path to settle, requests a Q measurement and narrows the interval toward the
// target Q. Stops with a one-cycle done pulse once |measured - desired| < TOL,
// or with a one-cycle fail pulse when the iteration budget or the interval runs out.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, abort      begin a run (accepted only when idle), cancel any run
//   desired_q         target Q, latched on an accepted start
//   i_ref_max         upper search bound, latched on an accepted start
//   meas_req          measurement request, high for the whole MEASURE state
//   meas_valid        measurement-complete strobe (ignored outside MEASURE)
//   measured_q        measurement data, qualified by meas_valid
//   i_ref             registered current reference to the analog front end
//   busy, done, fail  run active, success pulse, failure pulse
//   iter_count        evaluations completed in the current or last run
module q_tune_seq #(
  parameter int WIDTH    = 10,
  parameter int TOL      = 30,
  parameter int SETTLE   = 16,
  parameter int MAX_ITER = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] desired_q,
  input  logic [WIDTH-1:0] i_ref_max,
  output logic             meas_req,
  input  logic             meas_valid,
  input  logic [WIDTH-1:0] measured_q,
  output logic [WIDTH-1:0] i_ref,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [3:0]       iter_count
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_APPLY   = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_EVAL    = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;
  localparam logic [2:0] ST_FAIL    = 3'd6;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);
  localparam logic [WIDTH:0] TOL_W       = (WIDTH + 1)'(TOL);
  localparam logic [3:0]     MAX_ITER_W  = 4'(MAX_ITER);

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] des_q, des_d;
  logic [WIDTH-1:0] meas_q, meas_d;
  logic [WIDTH-1:0] i_ref_q, i_ref_d;
  logic [3:0]       iter_q, iter_d;
  logic [CW-1:0]    settle_q, settle_d;

  // Datapath helpers
  logic [WIDTH:0]        sum_w;
  logic [WIDTH-1:0]      mid;
  logic signed [WIDTH:0] diff;
  logic [WIDTH:0]        err_abs;
  logic                  go_up;
  logic [WIDTH-1:0]      next_a, next_b;
  logic [WIDTH:0]        gap;
  logic [3:0]            iter_inc;

  always_comb begin
    sum_w    = {1'b0, a_q} + {1'b0, b_q};
    mid      = WIDTH'(sum_w >> 1);
    diff     = $signed({1'b0, meas_q}) - $signed({1'b0, des_q});
    err_abs  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    go_up    = des_q > meas_q;
    next_a   = go_up ? i_ref_q : a_q;
    next_b   = go_up ? b_q : i_ref_q;
    // Collapse is judged on the interval the next step would search.
    gap      = {1'b0, next_b} - {1'b0, next_a};
    iter_inc = iter_q + 4'd1;
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    des_d    = des_q;
    meas_d   = meas_q;
    i_ref_d  = i_ref_q;
    iter_d   = iter_q;
    settle_d = settle_q;
    if (abort) begin
      // Abort wins over start and meas_val in every state.
      state_d = ST_IDLE;
      i_ref_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_d     = '0;
            b_d     = i_ref_max;
            des_d   = desired_q;
            iter_d  = '0;
            state_d = ST_APPLY;
          end
        end
        ST_APPLY: begin
          i_ref_d  = mid;
          settle_d = '0;
          state_d  = ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_d = ST_MEASURE;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        ST_MEASURE: begin
          if (meas_valid) begin
            meas_d  = measured_q;
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          iter_d = iter_inc;
          if (err_abs < TOL_W) begin
            state_d = ST_DONE;
          end else if (iter_inc == MAX_ITER_W || gap <= (WIDTH + 1)'(1)) begin
            i_ref_d = '0;
            state_d = ST_FAIL;
          end else begin
            a_d     = next_a;
            b_d     = next_b;
            state_d = ST_APPLY;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        ST_FAIL: state_d = ST_IDLE;
        default: begin
          i_ref_d = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      des_q    <= '0;
      meas_q   <= '0;
      i_ref_q  <= '0;
      iter_q   <= '0;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      des_q    <= des_d;
      meas_q   <= meas_d;
      i_ref_q  <= i_ref_d;
      iter_q   <= iter_d;
      settle_q <= settle_d;
    end
  end

  // Outputs decode straight from the state register, so reset clears them at once.
  assign meas_req   = (state_q == ST_MEASURE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign fail       = (state_q == ST_FAIL);
  assign i_ref      = i_ref_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_q_tune_seq.sv
// Directed bench for q_tune_seq with a behavioural plant returning a scaled
// copy of i_ref after a programmable delay.
module tb_q_tune_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [9:0] desired_q;
  logic [9:0] i_ref_max;
  logic       meas_req;
  logic       meas_valid;
  logic [9:0] measured_q;
  logic [9:0] i_ref;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] iter_count;

  // Plant controls
  logic plant_valid;
  logic inject_valid;
  logic plant_en;
  int   plant_mode;
  int   plant_delay;
  int   wcnt;

  // Monitor totals (only the monitor writes these)
  int   req_tot, done_tot, fail_tot, both_tot, meas_n;
  int   meas_log[16];
  int   last_done_iref, last_done_iter;
  logic prev_req;

  int   n_cmp = 0;
  int   n_err = 0;

  assign meas_valid = plant_valid | inject_valid;

  always #5 clk = ~clk;

  q_tune_seq dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .desired_q  (desired_q),
    .i_ref_max  (i_ref_max),
    .meas_req   (meas_req),
    .meas_valid (meas_valid),
    .measured_q (measured_q),
    .i_ref      (i_ref),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .iter_count (iter_count)
  );

  function automatic logic [9:0] plant_model(input int mode, input logic [9:0] x);
    case (mode)
      1:       return x >> 1;
      2:       return x >> 2;
      default: return x;
    endcase
  endfunction

  // Plant: answers meas_req after plant_delay cycles with a one-cycle strobe.
  initial begin
    plant_valid = 1'b0;
    measured_q  = '0;
    wcnt        = 0;
    forever begin
      @(negedge clk);
      plant_valid = 1'b0;
      if (meas_req && plant_en) begin
        if (wcnt >= plant_delay) begin
          plant_valid = 1'b1;
          measured_q  = plant_model(plant_mode, i_ref);
          wcnt        = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  initial begin
    req_tot = 0; done_tot = 0; fail_tot = 0; both_tot = 0; meas_n = 0;
    last_done_iref = -1; last_done_iter = -1; prev_req = 1'b0;
    for (int i = 0; i < 16; i++) meas_log[i] = -1;
    forever begin
      @(negedge clk);
      if (meas_req) req_tot++;
      if (meas_req && !prev_req) begin
        meas_log[meas_n % 16] = int'(i_ref);
        meas_n++;
      end
      prev_req = meas_req;
      if (done) begin
        done_tot++;
        last_done_iref = int'(i_ref);
        last_done_iter = int'(iter_count);
      end
      if (fail) fail_tot++;
      if (done && fail) both_tot++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(busy), 0);
  endtask

  int s_done, s_fail, s_req, s_meas, k;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; inject_valid = 1'b0;
    desired_q = 10'd500; i_ref_max = 10'd1023;
    plant_en = 1'b1; plant_mode = 0; plant_delay = 0;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_iref", int'(i_ref), 0);
    check("rst_req", int'(meas_req), 0);
    check("rst_done_fail", int'({done, fail}), 0);
    check("rst_iter", int'(iter_count), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Identity plant, converges on the first midpoint.
    s_done = done_tot; s_fail = fail_tot; s_req = req_tot;
    pulse_start();
    check("t1_busy", int'(busy), 1);
    wait_idle("t1_idle", 200);
    check("t1_done_cnt", done_tot - s_done, 1);
    check("t1_fail_cnt", fail_tot - s_fail, 0);
    check("t1_done_iref", last_done_iref, 511);
    check("t1_done_iter", last_done_iter, 1);
    check("t1_req_cycles", req_tot - s_req, 1);
    @(negedge clk);
    check("t1_iref_hold", int'(i_ref), 511);
    check("t1_iter_hold", int'(iter_count), 1);

    // Half-gain plant: 511 (Q 255) too low, then 767 (Q 383) within tolerance.
    plant_mode = 1; desired_q = 10'd400;
    s_done = done_tot; s_meas = meas_n;
    pulse_start();
    wait_idle("t2_idle", 300);
    check("t2_meas_cnt", meas_n - s_meas, 2);
    check("t2_first_iref", meas_log[s_meas % 16], 511);
    check("t2_second_iref", meas_log[(s_meas + 1) % 16], 767);
    check("t2_done_cnt", done_tot - s_done, 1);
    check("t2_done_iref", last_done_iref, 767);
    check("t2_done_iter", last_done_iter, 2);

    // Quarter-gain plant cannot reach 1023: a climbs until the interval collapses.
    plant_mode = 2; desired_q = 10'd1023;
    s_done = done_tot; s_fail = fail_tot; s_meas = meas_n;
    pulse_start();
    wait_idle("t3_idle", 1000);
    check("t3_fail_cnt", fail_tot - s_fail, 1);
    check("t3_done_cnt", done_tot - s_done, 0);
    check("t3_iter", int'(iter_count), 10);
    check("t3_iref", int'(i_ref), 0);
    check("t3_meas_cnt", meas_n - s_meas, 10);
    check("t3_last_iref", meas_log[(meas_n - 1) % 16], 1022);

    // Abort in the fifth SETTLE cycle.
    plant_mode = 0; desired_q = 10'd500;
    s_done = done_tot; s_fail = fail_tot;
    pulse_start();
    repeat (5) @(negedge clk);
    check("t4_pre_iref", int'(i_ref), 511);
    check("t4_pre_state", int'({busy, meas_req}), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_busy", int'(busy), 0);
    check("t4_iref", int'(i_ref), 0);
    check("t4_no_pulse", (done_tot - s_done) + (fail_tot - s_fail), 0);
    pulse_start();
    check("t4_restart_busy", int'(busy), 1);
    wait_idle("t4_idle", 200);
    check("t4_done_cnt", done_tot - s_done, 1);
    check("t4_fail_cnt", fail_tot - s_fail, 0);

    // Reset between edges while waiting on a measurement.
    plant_en = 1'b0;
    s_done = done_tot; s_fail = fail_tot;
    pulse_start();
    k = 0;
    while (!meas_req && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("t5_in_measure", int'(meas_req), 1);
    #2 rst = 1'b1;
    #1;
    check("t5_req_async", int'(meas_req), 0);
    check("t5_busy_async", int'(busy), 0);
    check("t5_iref_async", int'(i_ref), 0);
    check("t5_iter_async", int'(iter_count), 0);
    @(negedge clk);
    rst = 1'b0;
    inject_valid = 1'b1;
    @(negedge clk);
    inject_valid = 1'b0;
    @(negedge clk);
    check("t5_ignored_busy", int'(busy), 0);
    check("t5_ignored_req", int'(meas_req), 0);
    check("t5_no_pulse", (done_tot - s_done) + (fail_tot - s_fail), 0);
    plant_en = 1'b1;
    s_done = done_tot;
    pulse_start();
    wait_idle("t5_fresh_idle", 200);
    check("t5_fresh_done", done_tot - s_done, 1);
    check("t5_fresh_iref", last_done_iref, 511);
    check("t5_fresh_iter", last_done_iter, 1);

    // Slow measurement with a stray start during the run.
    plant_delay = 100;
    s_done = done_tot; s_req = req_tot; s_meas = meas_n;
    pulse_start();
    k = 0;
    while (!meas_req && k < 100) begin
      @(negedge clk);
      k++;
    end
    repeat (50) @(negedge clk);
    check("t6_req_held", int'(meas_req), 1);
    desired_q = 10'd100;
    pulse_start();
    wait_idle("t6_idle", 400);
    check("t6_req_cycles", req_tot - s_req, 101);
    check("t6_meas_cnt", meas_n - s_meas, 1);
    check("t6_done_cnt", done_tot - s_done, 1);
    check("t6_done_iref", last_done_iref, 511);
    check("t6_done_iter", last_done_iter, 1);
    check("never_both", both_tot, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
